// File: rtl/decoder_3x8_pulse.sv
// decoder_3x8_pulse: registered 3-to-8 one-hot decoder with timed output pulses.
// Codes arrive through a valid/ready handshake into a 2-entry in-order FIFO.
// Each popped code drives one bit of y for HOLD_CYCLES clocks. Consecutive
// pulses are separated by GAP_CYCLES clocks of y == 0.
module decoder_3x8_pulse #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       en,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic [7:0] dec_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Counter reload values. GAP_LOAD is unused when the gap is zero.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 32'd1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 32'd1);
  localparam logic       GAP_ZERO  = (GAP_CYCLES == 32'd0);

  // Binary code to one-hot strobe, bit index equals the code.
  function automatic logic [7:0] decode_onehot(input logic [2:0] code);
    decode_onehot = 8'h01 << code;
  endfunction

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [7:0] y_r;
  logic       y_valid_r;
  logic [7:0] dec_cnt_r;

  logic [2:0] fifo_mem_r [0:1];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] fifo_cnt_r;

  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       push_s;
  logic       decision_s;
  logic       start_s;
  logic [2:0] head_code_s;

  assign fifo_full_s  = (fifo_cnt_r == 2'd2);
  assign fifo_empty_s = (fifo_cnt_r == 2'd0);
  // Ready comes only from the registered full flag, so a full FIFO refuses
  // input even on a cycle where it pops.
  assign in_ready     = !fifo_full_s;
  assign push_s       = in_valid && !fifo_full_s;
  assign head_code_s  = fifo_mem_r[rd_ptr_r];
  assign start_s      = decision_s && en && !fifo_empty_s;

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign dec_cnt = dec_cnt_r;
  assign busy    = (state_r != IDLE) || !fifo_empty_s;

  // Identify cycles on which a new pulse may begin; en matters only here.
  always_comb begin
    decision_s = 1'b0;
    case (state_r)
      IDLE: begin
        decision_s = 1'b1;
      end
      ACTIVE: begin
        if ((cnt_r == 8'd0) && GAP_ZERO) begin
          decision_s = 1'b1;
        end else begin
          decision_s = 1'b0;
        end
      end
      GAP: begin
        if (cnt_r == 8'd0) begin
          decision_s = 1'b1;
        end else begin
          decision_s = 1'b0;
        end
      end
      default: begin
        decision_s = 1'b0;
      end
    endcase
  end

  // Two-entry in-order code FIFO; the pop happens on a pulse start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem_r[0] <= 3'd0;
      fifo_mem_r[1] <= 3'd0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= in_code;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (start_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, start_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Pulse sequencer: hold the one-hot value, then the gap, then pick the next code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      y_r       <= 8'h00;
      y_valid_r <= 1'b0;
      dec_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            y_r       <= decode_onehot(head_code_s);
            y_valid_r <= 1'b1;
            dec_cnt_r <= dec_cnt_r + 8'd1;
            cnt_r     <= HOLD_LOAD;
            state_r   <= ACTIVE;
          end else begin
            y_r       <= 8'h00;
            y_valid_r <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else if (GAP_ZERO) begin
            if (start_s) begin
              y_r       <= decode_onehot(head_code_s);
              y_valid_r <= 1'b1;
              dec_cnt_r <= dec_cnt_r + 8'd1;
              cnt_r     <= HOLD_LOAD;
              state_r   <= ACTIVE;
            end else begin
              y_r       <= 8'h00;
              y_valid_r <= 1'b0;
              state_r   <= IDLE;
            end
          end else begin
            y_r       <= 8'h00;
            y_valid_r <= 1'b0;
            cnt_r     <= GAP_LOAD;
            state_r   <= GAP;
          end
        end
        GAP: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else if (start_s) begin
            y_r       <= decode_onehot(head_code_s);
            y_valid_r <= 1'b1;
            dec_cnt_r <= dec_cnt_r + 8'd1;
            cnt_r     <= HOLD_LOAD;
            state_r   <= ACTIVE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 8'd0;
          y_r       <= 8'h00;
          y_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Testbench for decoder_3x8_pulse. Two instances: HOLD=4/GAP=1 and HOLD=1/GAP=0.
// A time-based reference model pushes expected pulses into per-instance
// queues. A monitor pops an entry each time a DUT pulse begins and compares it.
module tb_decoder_3x8_pulse;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 1;
  localparam int GAP_B  = 0;

  typedef struct {
    logic [2:0] code;
    int         edge_k;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0][2:0] in_code;
  logic [1:0]      en;
  logic [1:0][7:0] y;
  logic [1:0]      y_valid;
  logic [1:0]      busy;
  logic [1:0][7:0] dec_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [2:0] fq [2][$];
  exp_t       expq [2][$];
  int         k_now [2];
  int         next_dec [2];
  logic [7:0] cnt_m [2];
  logic [1:0] exp_ready = 2'b11;
  logic [1:0] exp_busy  = 2'b00;

  // Monitor state.
  logic       prev_v [2];
  logic [7:0] prev_y [2];
  int         run [2];

  always #5 clk = ~clk;

  decoder_3x8_pulse #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .en(en[0]), .y(y[0]), .y_valid(y_valid[0]),
    .busy(busy[0]), .dec_cnt(dec_cnt[0])
  );

  decoder_3x8_pulse #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .en(en[1]), .y(y[1]), .y_valid(y_valid[1]),
    .busy(busy[1]), .dec_cnt(dec_cnt[1])
  );

  function automatic int hold_of(input int i);
    return (i == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Model: a pulse starts at the first edge at/after the previous pulse's
  // hold+gap window where en is high and a code is queued.
  task automatic model_step(input int i);
    int         n_before;
    logic       st;
    exp_t       e;
    if (!rst_n) begin
      fq[i].delete();
      expq[i].delete();
      k_now[i]     = 0;
      next_dec[i]  = 0;
      cnt_m[i]     = 8'd0;
      exp_ready[i] = 1'b1;
      exp_busy[i]  = 1'b0;
    end else begin
      k_now[i]++;
      n_before = fq[i].size();
      st = (k_now[i] >= next_dec[i]) && (en[i] === 1'b1) && (n_before > 0);
      if (st) begin
        e.code      = fq[i].pop_front();
        cnt_m[i]    = cnt_m[i] + 8'd1;
        e.edge_k    = k_now[i];
        e.cnt       = cnt_m[i];
        next_dec[i] = k_now[i] + hold_of(i) + gap_of(i);
        expq[i].push_back(e);
      end
      if ((in_valid[i] === 1'b1) && (n_before < 2)) fq[i].push_back(in_code[i]);
      exp_ready[i] = (fq[i].size() < 2);
      exp_busy[i]  = (k_now[i] < next_dec[i]) || (fq[i].size() > 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Monitor: per-cycle form checks, plus a scoreboard pop at each pulse start.
  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_v[i] = 1'b0; prev_y[i] = 8'h00; run[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          prev_v[i] = 1'b0; prev_y[i] = 8'h00; run[i] = 0;
        end else begin
          chk($sformatf("y_form%0d", i),
              {31'd0, ($isunknown(y[i]) || !$onehot0(y[i]) || (y_valid[i] !== (y[i] != 8'h00)))},
              32'd0);
          chk($sformatf("in_ready%0d", i), {31'd0, in_ready[i]}, {31'd0, exp_ready[i]});
          chk($sformatf("busy%0d", i), {31'd0, busy[i]}, {31'd0, exp_busy[i]});
          if ((y_valid[i] === 1'b1) && (!prev_v[i] || run[i] == hold_of(i))) begin
            if (expq[i].size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_pulse%0d actual=%0h expected=none t=%0t", i, y[i], $time);
            end else begin
              exp_t e;
              logic [7:0] oh;
              e  = expq[i].pop_front();
              oh = 8'h01 << e.code;
              chk($sformatf("pulse_y%0d", i), {24'd0, y[i]}, {24'd0, oh});
              chk($sformatf("pulse_start%0d", i), k_now[i], e.edge_k);
              chk($sformatf("pulse_cnt%0d", i), {24'd0, dec_cnt[i]}, {24'd0, e.cnt});
            end
            run[i] = 1;
          end else if (y_valid[i] === 1'b1) begin
            run[i]++;
            chk($sformatf("pulse_hold%0d", i), {24'd0, y[i]}, {24'd0, prev_y[i]});
          end else begin
            if (prev_v[i]) chk($sformatf("pulse_width%0d", i), run[i], hold_of(i));
            run[i] = 0;
          end
          prev_v[i] = y_valid[i];
          prev_y[i] = y[i];
        end
      end
    end
  end

  // Push one code on instance i, waiting for the model's ready; caller sits at a negedge.
  task automatic send(input int i, input logic [2:0] c);
    int t;
    t = 0;
    while (!exp_ready[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++; failures++;
      $display("FAIL send_timeout%0d actual=%0d expected=<500", i, t);
    end
    in_valid[i] = 1'b1;
    in_code[i]  = c;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_busy != 2'b00 || expq[0].size() != 0 || expq[1].size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=<3000", t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int i);
    int t;
    t = 0;
    while (y_valid[i] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++; failures++;
      $display("FAIL wait_valid%0d actual=%0d expected=<100", i, t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_y%0d", tag, i), {24'd0, y[i]}, 32'd0);
      chk($sformatf("%s_yv%0d", tag, i), {31'd0, y_valid[i]}, 32'd0);
      chk($sformatf("%s_cnt%0d", tag, i), {24'd0, dec_cnt[i]}, 32'd0);
      chk($sformatf("%s_rdy%0d", tag, i), {31'd0, in_ready[i]}, 32'd1);
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy[i]}, 32'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 2'b00;
    in_code  = '0;
    en       = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single code 5 on the HOLD=4/GAP=1 instance.
    en = 2'b11;
    send(0, 3'd5);
    wait_idle();
    chk("t1_cnt", {24'd0, dec_cnt[0]}, 32'd1);
    chk("t1_busy", {31'd0, busy[0]}, 32'd0);

    // Sweep 0..7 honoring ready.
    for (int c = 0; c < 8; c++) send(0, 3'(c));
    wait_idle();
    chk("t2_cnt", {24'd0, dec_cnt[0]}, 32'd9);

    // Backpressure: fill with en low, attempt a refused third push.
    en[0] = 1'b0;
    send(0, 3'd2);
    send(0, 3'd6);
    chk("t3_full", {31'd0, in_ready[0]}, 32'd0);
    in_valid[0] = 1'b1;
    in_code[0]  = 3'd1;
    repeat (3) @(negedge clk);
    in_valid[0] = 1'b0;
    chk("t3_refused", {31'd0, in_ready[0]}, 32'd0);
    en[0] = 1'b1;
    wait_idle();
    chk("t3_cnt", {24'd0, dec_cnt[0]}, 32'd11);

    // Back-to-back strobes on the HOLD=1/GAP=0 instance.
    en[1] = 1'b0;
    send(1, 3'd1);
    send(1, 3'd7);
    en[1] = 1'b1;
    wait_idle();
    chk("t4_cnt", {24'd0, dec_cnt[1]}, 32'd2);

    // en dropped during an active pulse: pulse completes, next code waits.
    send(0, 3'd3);
    send(0, 3'd4);
    wait_valid(0);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_wait_y", {24'd0, y[0]}, 32'd0);
    chk("t5_wait_busy", {31'd0, busy[0]}, 32'd1);
    en[0] = 1'b1;
    wait_idle();

    // Asynchronous reset during a pulse with codes still queued.
    send(0, 3'd5);
    send(0, 3'd6);
    send(1, 3'd2);
    send(0, 3'd7);
    wait_valid(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_after_y", {24'd0, y[0]}, 32'd0);
    chk("t5_after_busy", {31'd0, busy[0]}, 32'd0);

    // 256 pops wrap the count back to zero.
    for (int n = 0; n < 256; n++) send(1, 3'($urandom_range(0, 7)));
    wait_idle();
    chk("t6_wrap", {24'd0, dec_cnt[1]}, 32'd0);

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_code[i]  = 3'($urandom_range(0, 7));
        en[i]       = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
    end
    in_valid = 2'b00;
    en       = 2'b11;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
